// File: rtl/reg_file.sv
// reg_file: two-read, one-write register file for the single-cycle RISC datapath.
// Register 0 is hard-wired to zero. The stack-pointer entry resets to SP_INIT.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-through
// forwarding from rd_data onto a read port that addresses the write target.
module reg_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    SP_INDEX   = 2,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_0FFC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Entry 0 has no storage; the array starts at index 1.
    logic [DATA_WIDTH-1:0] regs_reg [1:NUM_REGS-1];

    // Write enable qualified so that index 0 never reaches the array.
    logic write_en;
    assign write_en = reg_write && (rd_addr != '0);

    // Storage: async clear to reset values, one write per rising edge otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_reg[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
        end else if (write_en) begin
            regs_reg[rd_addr] <= rd_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed while reset is high so outputs show reset values.
    logic fwd_en;
    assign fwd_en = write_en && !reset;
`endif

    // Read port 1: zero for r0, optional forwarding, else stored contents.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (fwd_en && (rs1_addr == rd_addr)) begin
                rs1_data = rd_data;
            end else begin
                rs1_data = regs_reg[rs1_addr];
            end
`else
            rs1_data = regs_reg[rs1_addr];
`endif
        end
    end

    // Read port 2: same behaviour as read port 1, independent address.
    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (fwd_en && (rs2_addr == rd_addr)) begin
                rs2_data = rd_data;
            end else begin
                rs2_data = regs_reg[rs2_addr];
            end
`else
            rs2_data = regs_reg[rs2_addr];
`endif
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Expected values are hand-computed constants; REGFILE_BYPASS_EN selects the
// same-cycle read expectation to match the build under test.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int n_compared   = 0;
    int n_mismatched = 0;

    reg_file dut (
        .clk      (clk),
        .reset    (reset),
        .reg_write(reg_write),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
        $display("check %-22s got %h expected %h", tag, obs, exp);
    endtask

    // Single write of data to addr on the next rising edge, then write disabled.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = addr;
        rd_data   = data;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    initial begin
        logic [31:0] same_cycle_exp;
        reset     = 1'b0;
        reg_write = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
        rs1_addr  = 5'd2;
        rs2_addr  = 5'd5;

        // Reset pulse with no clock edge in between (first posedge is at 5ns).
        #1 reset = 1'b1;
        #1;
        check("reset_held_sp", rs1_data, 32'h0000_0FFC);
        reset = 1'b0;
        #1;
        check("reset_sp_r2", rs1_data, 32'h0000_0FFC);
        check("reset_r5", rs2_data, 32'h0);

        // Basic write then read on both ports.
        write_reg(5'd7, 32'hDEAD_BEEF);
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        check("wr_r7_port1", rs1_data, 32'hDEAD_BEEF);
        check("wr_r7_port2", rs2_data, 32'hDEAD_BEEF);
        rs2_addr = 5'd8;
        #1;
        check("r8_untouched", rs2_data, 32'h0);

        // Write to r0 is dropped and disturbs nothing.
        write_reg(5'd0, 32'hFFFF_FFFF);
        rs1_addr = 5'd0;
        rs2_addr = 5'd2;
        #1;
        check("r0_reads_zero", rs1_data, 32'h0);
        check("r0_wr_sp_kept", rs2_data, 32'h0000_0FFC);
        rs1_addr = 5'd7;
        rs2_addr = 5'd1;
        #1;
        check("r0_wr_r7_kept", rs1_data, 32'hDEAD_BEEF);
        check("r0_wr_r1_kept", rs2_data, 32'h0);

        // Write enable low: nothing stored.
        @(negedge clk);
        reg_write = 1'b0;
        rd_addr   = 5'd9;
        rd_data   = 32'h1234_5678;
        rs1_addr  = 5'd9;
        @(posedge clk);
        #1;
        check("we_low_r9", rs1_data, 32'h0);

        // Same-cycle read of the write target.
        write_reg(5'd3, 32'h11);
        rs1_addr = 5'd3;
        #1;
        check("r3_initial", rs1_data, 32'h11);
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h22;
`else
        same_cycle_exp = 32'h11;
`endif
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd3;
        rd_data   = 32'h22;
        rs1_addr  = 5'd3;
        rs2_addr  = 5'd7;
        #1;
        check("same_cycle_r3", rs1_data, same_cycle_exp);
        check("same_cycle_other", rs2_data, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        check("after_edge_r3", rs1_data, 32'h22);

        // r0 never forwarded even with a pending write addressed to it.
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd0;
        rd_data   = 32'hFFFF_FFFF;
        rs1_addr  = 5'd0;
        #1;
        check("r0_no_bypass", rs1_data, 32'h0);
        @(posedge clk);
        #1;
        reg_write = 1'b0;

        // Reset mid-cycle with a write pending.
        write_reg(5'd4, 32'hA5A5_A5A5);
        rs1_addr = 5'd4;
        rs2_addr = 5'd2;
        #1;
        check("r4_written", rs1_data, 32'hA5A5_A5A5);
        reg_write = 1'b1;
        rd_addr   = 5'd4;
        rd_data   = 32'h5;
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_r4", rs1_data, 32'h0);
        check("mid_reset_sp", rs2_data, 32'h0000_0FFC);
        @(posedge clk);
        #1;
        check("reset_held_edge_r4", rs1_data, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        reset     = 1'b0;
        rs2_addr  = 5'd7;
        #1;
        check("post_reset_r4", rs1_data, 32'h0);
        check("post_reset_r7", rs2_data, 32'h0);

        // Writes resume once reset is released.
        write_reg(5'd4, 32'h5);
        #1;
        check("resume_r4", rs1_data, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
